// File: rtl/key_debounce.sv
// Pushbutton front end: 2-flop sync, press/release debounce, down/up/long pulses.
// Optional auto-repeat of key_down while long-held: KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce #(
  parameter int KEY_ACTIVE_LOW  = 0,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int LONG_CYCLES     = 65536,
  parameter int REPEAT_CYCLES   = 16384,
  parameter int CNT_W           = 17
) (
  input  logic clock,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic key_down,
  output logic key_up,
  output logic key_long
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > LONG_CYCLES)
                         ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYCLES)
                         ? MAX_AB : REPEAT_CYCLES;

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1
      || $clog2(MAX_CYC + 1) > CNT_W) begin : g_bad_cfg
    $error("key_debounce: bad cycle counts or CNT_W too small");
  end

  localparam logic REST_LVL = (KEY_ACTIVE_LOW != 0);

  localparam logic [CNT_W-1:0] DEB_N  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_N = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_N  = CNT_W'(REPEAT_CYCLES);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic             ret_long;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             sync1;
  logic             sync2;
  logic             act;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= REST_LVL;
      sync2 <= REST_LVL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign act     = sync2 ^ REST_LVL;
  assign cnt_inc = cnt + ONE;

  // A one-cycle debounce accepts on the very first sample, so IDLE and
  // the hold states short-circuit the wait states in that case.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ret_long  <= 1'b0;
      cnt       <= '0;
      key_level <= 1'b0;
      key_down  <= 1'b0;
      key_up    <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_down <= 1'b0;
      key_up   <= 1'b0;
      key_long <= 1'b0;
      unique case (state)
        IDLE: begin
          if (act) begin
            if (DEB_N == ONE) begin
              state     <= HELD;
              cnt       <= '0;
              key_down  <= 1'b1;
              key_level <= 1'b1;
            end else begin
              state <= PRESS_WAIT;
              cnt   <= ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!act) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_inc == DEB_N) begin
            state     <= HELD;
            cnt       <= '0;
            key_down  <= 1'b1;
            key_level <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          if (!act) begin
            ret_long <= 1'b0;
            if (DEB_N == ONE) begin
              state     <= IDLE;
              cnt       <= '0;
              key_up    <= 1'b1;
              key_level <= 1'b0;
            end else begin
              state <= RELEASE_WAIT;
              cnt   <= ONE;
            end
          end else if (cnt_inc == LONG_N) begin
            state    <= LONG_HELD;
            cnt      <= '0;
            key_long <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LONG_HELD: begin
          if (!act) begin
            ret_long <= 1'b1;
            if (DEB_N == ONE) begin
              state     <= IDLE;
              cnt       <= '0;
              key_up    <= 1'b1;
              key_level <= 1'b0;
            end else begin
              state <= RELEASE_WAIT;
              cnt   <= ONE;
            end
          end else begin
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            if (cnt_inc == REP_N) begin
              cnt      <= '0;
              key_down <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
`else
            cnt <= '0;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (act) begin
            state <= ret_long ? LONG_HELD : HELD;
            cnt   <= '0;
          end else if (cnt_inc == DEB_N) begin
            state     <= IDLE;
            cnt       <= '0;
            key_up    <= 1'b1;
            key_level <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: active-high instance a, active-low instance b.
module tb_key_debounce;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_a = 1'b0;
  logic key_b = 1'b1;
  logic lvl_a, dn_a, up_a, lg_a;
  logic lvl_b, dn_b, up_b, lg_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_multi = 0;
  int n_dn[2];
  int n_up[2];
  int n_lg[2];
  int t_dn[2];
  int t_up[2];
  int t_lg[2];
  int t0;
  int t1;

  key_debounce #(
    .KEY_ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG),
    .REPEAT_CYCLES(REP), .CNT_W(17)
  ) u_a (
    .clock(clock), .reset(reset), .key_in(key_a),
    .key_level(lvl_a), .key_down(dn_a), .key_up(up_a), .key_long(lg_a)
  );

  key_debounce #(
    .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG),
    .REPEAT_CYCLES(REP), .CNT_W(17)
  ) u_b (
    .clock(clock), .reset(reset), .key_in(key_b),
    .key_level(lvl_b), .key_down(dn_b), .key_up(up_b), .key_long(lg_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      n_dn[i] = 0; n_up[i] = 0; n_lg[i] = 0;
      t_dn[i] = -1; t_up[i] = -1; t_lg[i] = -1;
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(posedge clock) begin
    cyc++;
    #1;
    if (dn_a) begin n_dn[0]++; t_dn[0] = cyc; end
    if (up_a) begin n_up[0]++; t_up[0] = cyc; end
    if (lg_a) begin n_lg[0]++; t_lg[0] = cyc; end
    if (dn_b) begin n_dn[1]++; t_dn[1] = cyc; end
    if (up_b) begin n_up[1]++; t_up[1] = cyc; end
    if (lg_b) begin n_lg[1]++; t_lg[1] = cyc; end
    if (int'(dn_a) + int'(up_a) + int'(lg_a) > 1 ||
        int'(dn_b) + int'(up_b) + int'(lg_b) > 1)
      n_multi++;
  end

  initial begin
    clr();
    @(negedge clock);
    chk("rst_level_a", int'(lvl_a), 0);
    chk("rst_down_a", int'(dn_a), 0);
    chk("rst_up_a", int'(up_a), 0);
    chk("rst_long_a", int'(lg_a), 0);
    chk("rst_level_b", int'(lvl_b), 0);
    wait_n(2);
    reset = 1'b0;
    wait_n(3);

    // clean press and release
    clr();
    key_a = 1'b1; t0 = cyc;
    wait_n(8);
    chk("press_down_cnt", n_dn[0], 1);
    chk("press_down_edge", t_dn[0], t0 + DEB + 2);
    chk("press_level", int'(lvl_a), 1);
    wait_n(10);
    key_a = 1'b0; t0 = cyc;
    wait_n(8);
    chk("rel_up_cnt", n_up[0], 1);
    chk("rel_up_edge", t_up[0], t0 + DEB + 2);
    chk("rel_level", int'(lvl_a), 0);
    chk("rel_no_long", n_lg[0], 0);
    chk("rel_one_down", n_dn[0], 1);

    // glitch of 3 cycles
    clr();
    key_a = 1'b1;
    wait_n(3);
    key_a = 1'b0;
    wait_n(12);
    chk("glitch_no_down", n_dn[0], 0);
    chk("glitch_level", int'(lvl_a), 0);
    key_a = 1'b1; t0 = cyc;
    wait_n(8);
    chk("repress_down_edge", t_dn[0], t0 + DEB + 2);

    // release bounce
    clr();
    key_a = 1'b0;
    wait_n(2);
    key_a = 1'b1;
    wait_n(1);
    key_a = 1'b0; t0 = cyc;
    wait_n(10);
    chk("bounce_up_cnt", n_up[0], 1);
    chk("bounce_up_edge", t_up[0], t0 + DEB + 2);
    chk("bounce_no_down", n_dn[0], 0);
    chk("bounce_level", int'(lvl_a), 0);

    // long press with optional repeat
    wait_n(4);
    clr();
    key_a = 1'b1; t0 = cyc;
    wait_n(36);
    chk("long_cnt", n_lg[0], 1);
    chk("long_edge", t_lg[0], t0 + DEB + 2 + LNG);
    chk("long_dn_cnt_a", n_dn[0], AR ? 2 : 1);
    chk("long_dn_edge_a", t_dn[0], AR ? t0 + 34 : t0 + 6);
    wait_n(16);
    chk("long_dn_cnt_b", n_dn[0], AR ? 4 : 1);
    chk("long_dn_edge_b", t_dn[0], AR ? t0 + 50 : t0 + 6);
    key_a = 1'b0; t1 = cyc;
    wait_n(8);
    chk("long_rel_up", n_up[0], 1);
    chk("long_rel_edge", t_up[0], t1 + DEB + 2);
    chk("long_rel_dn", n_dn[0], AR ? 4 : 1);
    chk("long_rel_lg", n_lg[0], 1);

    // release lands on the long threshold
    wait_n(4);
    clr();
    key_a = 1'b1; t0 = cyc;
    wait_n(LNG + DEB - 1);
    key_a = 1'b0; t1 = cyc;
    wait_n(10);
    chk("thr_no_long", n_lg[0], 0);
    chk("thr_up_cnt", n_up[0], 1);
    chk("thr_up_edge", t_up[0], t1 + DEB + 2);
    chk("thr_dn_cnt", n_dn[0], 1);

    // active-low press
    clr();
    key_b = 1'b0; t0 = cyc;
    wait_n(8);
    chk("al_down_cnt", n_dn[1], 1);
    chk("al_down_edge", t_dn[1], t0 + DEB + 2);
    chk("al_level", int'(lvl_b), 1);

    // async reset mid-hold, key still pressed
    wait_n(2);
    #2 reset = 1'b1;
    #1;
    chk("arst_level", int'(lvl_b), 0);
    chk("arst_down", int'(dn_b), 0);
    chk("arst_up", int'(up_b), 0);
    chk("arst_long", int'(lg_b), 0);
    clr();
    wait_n(2);
    reset = 1'b0; t0 = cyc;
    wait_n(10);
    chk("arst_no_up", n_up[1], 0);
    chk("arst_redown_cnt", n_dn[1], 1);
    chk("arst_redown_edge", t_dn[1], t0 + DEB + 2);
    chk("arst_a_quiet", n_dn[0], 0);
    key_b = 1'b1; t0 = cyc;
    wait_n(8);
    chk("al_up_edge", t_up[1], t0 + DEB + 2);
    chk("al_level_rel", int'(lvl_b), 0);

    chk("one_pulse_per_cycle", n_multi, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
